// File: rtl/rtc_timer_bank_if.sv
// Configuration/status bundle between the APB register file and the timer bank.
// Latency: none, pure wiring.
// Backpressure: none; config strobes are single-cycle pulses always accepted.
interface rtc_timer_bank_if #(
   parameter int N_TIMERS    = 4,
   parameter int CNT_WIDTH   = 24,
   parameter int PRESC_WIDTH = 16,
   parameter int SEL_WIDTH   = (N_TIMERS > 1) ? $clog2(N_TIMERS) : 1
);
   // register-file side -> timer bank
   logic                          presc_update_i;
   logic [PRESC_WIDTH-1:0]        presc_div_i;
   logic                          cfg_we_i;
   logic [SEL_WIDTH-1:0]          cfg_sel_i;
   logic                          cfg_enable_i;
   logic [1:0]                    cfg_mode_i;
   logic [CNT_WIDTH-1:0]          cfg_target_i;
   logic [N_TIMERS-1:0]           pending_clr_i;
   logic [N_TIMERS-1:0]           irq_mask_i;

   // timer bank -> register file / interrupt controller
   logic                          tick_o;
   logic [N_TIMERS*CNT_WIDTH-1:0] value_o;
   logic [N_TIMERS-1:0]           active_o;
   logic [N_TIMERS-1:0]           event_o;
   logic [N_TIMERS-1:0]           pending_o;
   logic                          irq_o;

   modport master (
      output presc_update_i, presc_div_i, cfg_we_i, cfg_sel_i, cfg_enable_i,
             cfg_mode_i, cfg_target_i, pending_clr_i, irq_mask_i,
      input  tick_o, value_o, active_o, event_o, pending_o, irq_o
   );

   modport slave (
      input  presc_update_i, presc_div_i, cfg_we_i, cfg_sel_i, cfg_enable_i,
             cfg_mode_i, cfg_target_i, pending_clr_i, irq_mask_i,
      output tick_o, value_o, active_o, event_o, pending_o, irq_o
   );
endinterface

// File: rtl/rtc_timer_bank.sv
// Shared prescaler feeding N one-shot/periodic/free-running timer channels with sticky pending + irq.
// Latency: event_o combinational in the match cycle; pending/irq one cycle later; config visible next cycle.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
module rtc_timer_bank #(
   parameter int N_TIMERS    = 4,
   parameter int CNT_WIDTH   = 24,
   parameter int PRESC_WIDTH = 16,
   parameter int SEL_WIDTH   = (N_TIMERS > 1) ? $clog2(N_TIMERS) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   rtc_timer_bank_if.slave bus
);

   typedef logic [CNT_WIDTH-1:0]   cnt_t;
   typedef logic [PRESC_WIDTH-1:0] presc_t;

   // 1 Hz tick from the 32.768 kHz clock
   localparam presc_t DIV_RST = presc_t'(32'h7FFF);

   presc_t              presc_cnt_q, presc_cnt_d;
   presc_t              presc_div_q, presc_div_d;
   cnt_t                cnt_q    [N_TIMERS];
   cnt_t                cnt_d    [N_TIMERS];
   cnt_t                target_q [N_TIMERS];
   cnt_t                target_d [N_TIMERS];
   logic [1:0]          mode_q   [N_TIMERS];
   logic [1:0]          mode_d   [N_TIMERS];
   logic [N_TIMERS-1:0] active_q, active_d;
   logic [N_TIMERS-1:0] pending_q, pending_d;

   logic                tick;
   logic [N_TIMERS-1:0] evt;
   logic [N_TIMERS*CNT_WIDTH-1:0] value_flat;

   // Prescaler: a divider reload wins over counting and swallows that cycle's tick
   always_comb begin
      presc_cnt_d = presc_cnt_q;
      presc_div_d = presc_div_q;
      tick        = 1'b0;
      if (bus.presc_update_i) begin
         presc_cnt_d = '0;
         presc_div_d = bus.presc_div_i;
      end else if (presc_cnt_q == presc_div_q) begin
         tick        = 1'b1;
         presc_cnt_d = '0;
      end else begin
         presc_cnt_d = presc_cnt_q + presc_t'(1);
      end
   end

   // Channel next state: config write, then tick-driven count/match, else hold
   always_comb begin
      active_d  = active_q;
      pending_d = pending_q;
      evt       = '0;
      for (int k = 0; k < N_TIMERS; k++) begin
         cnt_d[k]    = cnt_q[k];
         target_d[k] = target_q[k];
         mode_d[k]   = mode_q[k];
         // sel == k can only match an existing channel, so out-of-range selects fall through
         if (bus.cfg_we_i && (bus.cfg_sel_i == SEL_WIDTH'(k))) begin
            target_d[k] = bus.cfg_target_i;
            mode_d[k]   = bus.cfg_mode_i;
            active_d[k] = bus.cfg_enable_i;
            cnt_d[k]    = '0;
         end else if (active_q[k] && tick) begin
            // free-running modes (1x) never compare, they just wrap
            if (!mode_q[k][1] && (cnt_q[k] == target_q[k])) begin
               evt[k]   = 1'b1;
               cnt_d[k] = '0;
               if (mode_q[k] == 2'b00) begin
                  active_d[k] = 1'b0;
               end
            end else begin
               cnt_d[k] = cnt_q[k] + cnt_t'(1);
            end
         end
         // a fresh event beats a clear arriving in the same cycle
         if (evt[k]) begin
            pending_d[k] = 1'b1;
         end else if (bus.pending_clr_i[k]) begin
            pending_d[k] = 1'b0;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         presc_cnt_q <= '0;
         presc_div_q <= DIV_RST;
         active_q    <= '0;
         pending_q   <= '0;
         for (int k = 0; k < N_TIMERS; k++) begin
            cnt_q[k]    <= '0;
            target_q[k] <= '0;
            mode_q[k]   <= 2'b00;
         end
      end else begin
         presc_cnt_q <= presc_cnt_d;
         presc_div_q <= presc_div_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         target_q    <= target_d;
         mode_q      <= mode_d;
      end
   end

   // Pack counters for readback; everything reads 0 while reset is held
   always_comb begin
      value_flat = '0;
      for (int k = 0; k < N_TIMERS; k++) begin
         value_flat[k*CNT_WIDTH +: CNT_WIDTH] = rst_i ? '0 : cnt_q[k];
      end
   end

   assign bus.value_o   = value_flat;
   assign bus.tick_o    = tick & ~rst_i;
   assign bus.event_o   = rst_i ? '0 : evt;
   assign bus.active_o  = rst_i ? '0 : active_q;
   assign bus.pending_o = rst_i ? '0 : pending_q;
   assign bus.irq_o     = ~rst_i & (|(pending_q & bus.irq_mask_i));

endmodule

// File: tb/tb_rtc_timer_bank.sv
module tb_rtc_timer_bank;
   localparam int NT = 5;
   localparam int CW = 4;
   localparam int PW = 16;
   localparam int SW = 3;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   rtc_timer_bank_if #(.N_TIMERS(NT), .CNT_WIDTH(CW), .PRESC_WIDTH(PW), .SEL_WIDTH(SW)) bus ();

   rtc_timer_bank #(.N_TIMERS(NT), .CNT_WIDTH(CW), .PRESC_WIDTH(PW), .SEL_WIDTH(SW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // move to the middle of the next cycle and drop the single-cycle strobes
   task automatic nxt();
      @(negedge clk_i);
      #1;
      bus.cfg_we_i       = 1'b0;
      bus.presc_update_i = 1'b0;
      bus.pending_clr_i  = '0;
      #1;
   endtask

   task automatic cfg(input int sel, input logic en, input logic [1:0] mode, input int tgt);
      bus.cfg_we_i     = 1'b1;
      bus.cfg_sel_i    = SW'(sel);
      bus.cfg_enable_i = en;
      bus.cfg_mode_i   = mode;
      bus.cfg_target_i = CW'(tgt);
   endtask

   task automatic presc(input int div);
      bus.presc_update_i = 1'b1;
      bus.presc_div_i    = PW'(div);
   endtask

   function automatic logic [CW-1:0] val(input int k);
      return bus.value_o[k*CW +: CW];
   endfunction

   initial begin
      int              c;
      logic [31:0]     vec;
      logic [NT-1:0]   acc;
      logic [NT*CW-1:0] vor;

      bus.presc_update_i = 1'b0;
      bus.presc_div_i    = '0;
      bus.cfg_we_i       = 1'b0;
      bus.cfg_sel_i      = '0;
      bus.cfg_enable_i   = 1'b0;
      bus.cfg_mode_i     = 2'b00;
      bus.cfg_target_i   = '0;
      bus.pending_clr_i  = '0;
      bus.irq_mask_i     = '1;

      // ---- reset state
      nxt();
      nxt();
      chk("rst_tick",    64'(bus.tick_o),    64'd0);
      chk("rst_value",   64'(bus.value_o),   64'd0);
      chk("rst_active",  64'(bus.active_o),  64'd0);
      chk("rst_event",   64'(bus.event_o),   64'd0);
      chk("rst_pending", 64'(bus.pending_o), 64'd0);
      chk("rst_irq",     64'(bus.irq_o),     64'd0);

      // ---- reset divider 'h7FFF: first tick in cycle 32767 after release
      rst_i = 1'b0;
      #1;
      c = 0;
      while (!bus.tick_o && c < 40000) begin
         nxt();
         c++;
      end
      chk("div_reset_first_tick", 64'(c), 64'd32767);

      // ---- update in a tick cycle suppresses the tick; then div=3 -> tick every 4
      presc(3);
      #1;
      chk("upd_no_tick", 64'(bus.tick_o), 64'd0);
      vec = '0;
      for (int off = 1; off <= 12; off++) begin
         nxt();
         vec[off-1] = bus.tick_o;
      end
      chk("presc_div3", 64'(vec[11:0]), 64'h888);

      // ---- one-shot ch0, target 5, div 0
      nxt();
      bus.irq_mask_i = 5'b00001;
      presc(0);
      cfg(0, 1'b1, 2'b00, 5);
      #1;
      vec = '0;
      for (int off = 1; off <= 7; off++) begin
         nxt();
         vec[off-1] = bus.event_o[0];
         if (off == 1) begin
            chk("os_start_val", 64'(val(0)), 64'd0);
            chk("os_start_act", 64'(bus.active_o[0]), 64'd1);
         end
         if (off == 3) chk("os_mid_val", 64'(val(0)), 64'd2);
      end
      chk("os_event_cycle", 64'(vec[6:0]), 64'h20);
      chk("os_done_act",  64'(bus.active_o[0]),  64'd0);
      chk("os_done_val",  64'(val(0)),           64'd0);
      chk("os_pending",   64'(bus.pending_o[0]), 64'd1);
      chk("os_irq_mask1", 64'(bus.irq_o),        64'd1);
      nxt();
      nxt();
      chk("os_hold_val", 64'(val(0)), 64'd0);
      bus.irq_mask_i = 5'b00000;
      #1;
      chk("os_irq_mask0", 64'(bus.irq_o), 64'd0);
      bus.pending_clr_i = 5'b00001;
      nxt();
      chk("os_pending_clr", 64'(bus.pending_o[0]), 64'd0);

      // ---- periodic ch2, target 2, div 1: events every 6 cycles
      nxt();
      presc(1);
      cfg(2, 1'b1, 2'b01, 2);
      #1;
      vec = '0;
      acc = '0;
      for (int off = 1; off <= 31; off++) begin
         nxt();
         vec[off-1] = bus.event_o[2];
         acc |= bus.event_o & 5'b11011;
      end
      chk("per_events", 64'(vec[30:0]), 64'h20820820);
      chk("per_others", 64'(acc), 64'd0);

      // ---- periodic target 0: event on every tick
      nxt();
      presc(1);
      cfg(2, 1'b1, 2'b01, 0);
      #1;
      vec = '0;
      for (int off = 1; off <= 8; off++) begin
         nxt();
         vec[off-1] = bus.event_o[2];
      end
      chk("per_tgt0", 64'(vec[7:0]), 64'hAA);
      nxt();
      cfg(2, 1'b0, 2'b01, 0);
      bus.pending_clr_i = '1;
      nxt();
      chk("per_off_pending", 64'(bus.pending_o), 64'd0);
      chk("per_off_active",  64'(bus.active_o),  64'd0);

      // ---- free-running ch1 wraps 15 -> 0 with no event
      nxt();
      presc(0);
      cfg(1, 1'b1, 2'b10, 0);
      #1;
      acc = '0;
      for (int off = 1; off <= 18; off++) begin
         nxt();
         chk("fr_val", 64'(val(1)), 64'((off - 1) % 16));
         acc |= bus.event_o;
      end
      chk("fr_no_event",   64'(acc),           64'd0);
      chk("fr_no_pending", 64'(bus.pending_o), 64'd0);
      nxt();
      cfg(1, 1'b0, 2'b00, 0);

      // ---- pending clear in the event cycle: set wins
      nxt();
      cfg(0, 1'b1, 2'b00, 2);
      #1;
      nxt();
      nxt();
      nxt();
      bus.pending_clr_i = 5'b00001;
      #1;
      chk("clr_evt", 64'(bus.event_o[0]), 64'd1);
      nxt();
      chk("set_wins", 64'(bus.pending_o[0]), 64'd1);
      bus.pending_clr_i = 5'b00001;
      nxt();
      chk("clr_after", 64'(bus.pending_o[0]), 64'd0);

      // ---- config write to ch3 in its match cycle
      nxt();
      cfg(3, 1'b1, 2'b01, 3);
      #1;
      nxt();
      nxt();
      nxt();
      chk("col_pre_val", 64'(val(3)), 64'd2);
      nxt();
      chk("col_pre_match", 64'(bus.event_o[3]), 64'd1);
      cfg(3, 1'b1, 2'b01, 3);
      #1;
      chk("col_evt_suppr", 64'(bus.event_o[3]), 64'd0);
      nxt();
      chk("col_val0",    64'(val(3)),           64'd0);
      chk("col_pending", 64'(bus.pending_o[3]), 64'd0);
      chk("col_active",  64'(bus.active_o[3]),  64'd1);
      cfg(3, 1'b0, 2'b00, 0);
      nxt();
      chk("idle_values", 64'(bus.value_o), 64'd0);

      // ---- cfg_sel = N_TIMERS is ignored
      cfg(NT, 1'b1, 2'b01, 0);
      acc = '0;
      nxt();
      acc |= bus.event_o;
      nxt();
      acc |= bus.event_o;
      nxt();
      chk("sel_oob_active", 64'(bus.active_o), 64'd0);
      chk("sel_oob_value",  64'(bus.value_o),  64'd0);
      chk("sel_oob_event",  64'(acc),          64'd0);

      // ---- reset during periodic counting
      nxt();
      bus.irq_mask_i = '1;
      presc(1);
      cfg(2, 1'b1, 2'b01, 2);
      #1;
      for (int off = 1; off <= 7; off++) nxt();
      chk("mr_pending", 64'(bus.pending_o[2]), 64'd1);
      chk("mr_irq",     64'(bus.irq_o),        64'd1);
      nxt();
      nxt();
      chk("mr_val_pre", 64'(val(2)), 64'd1);
      rst_i = 1'b1;
      nxt();
      chk("mr_tick",    64'(bus.tick_o),    64'd0);
      chk("mr_value",   64'(bus.value_o),   64'd0);
      chk("mr_active",  64'(bus.active_o),  64'd0);
      chk("mr_event",   64'(bus.event_o),   64'd0);
      chk("mr_pending0", 64'(bus.pending_o), 64'd0);
      chk("mr_irq0",    64'(bus.irq_o),     64'd0);
      rst_i = 1'b0;
      acc = '0;
      vor = '0;
      for (int off = 1; off <= 20; off++) begin
         nxt();
         acc |= bus.active_o | bus.event_o | bus.pending_o;
         vor |= bus.value_o;
      end
      chk("post_rst_idle",  64'(acc), 64'd0);
      chk("post_rst_value", 64'(vor), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
